// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: responder state encoding, bus IDs and the
// configuration ROM word layout used by the matching initiator.
package sccb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ID,
    ACK_ID,
    SUB_ADDR,
    ACK_SUB,
    WR_DATA,
    ACK_DATA,
    RD_DATA,
    RD_ACK,
    IGNORE
  } sccb_state_e;

  localparam logic [7:0] SCCB_WRITE_ID = 8'h42;
  localparam logic [7:0] SCCB_READ_ID  = 8'h43;

  // ROM word: {last_entry, sub_address, data}
  localparam int ROM_WORD_W   = 17;
  localparam int ROM_LAST_BIT = 16;
  localparam int ROM_SUB_MSB  = 15;
  localparam int ROM_SUB_LSB  = 8;
  localparam int ROM_DATA_MSB = 7;
  localparam int ROM_DATA_LSB = 0;

  function automatic logic [ROM_WORD_W-1:0] rom_word(input logic       last,
                                                     input logic [7:0] sub,
                                                     input logic [7:0] data);
    return {last, sub, data};
  endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Metastability synchronizer for one open-drain bus line, plus single-cycle
// rise/fall flags derived from the synchronized level. Flops reset to the idle-high bus.
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic xclk,
  input  logic reset_n,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge xclk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync[0] <= i_line;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/sccb_responder.sv
// SCCB slave: accepts sub-address + data writes into a 256x8 register file and
// serves sequential reads from it. All bus timing is sampled on xclk.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR    = SCCB_WRITE_ID,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       xclk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_drive_low,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [7:0] write_count,
  output logic       busy
);

  sccb_state_e r_state, w_nxt_state;
  logic [3:0]  r_bit_cnt, w_nxt_bit_cnt;
  logic [7:0]  r_shift, w_nxt_shift;
  logic [7:0]  r_ptr, w_nxt_ptr;
  logic [7:0]  r_wr_addr, w_nxt_wr_addr;
  logic [7:0]  r_wr_data, w_nxt_wr_data;
  logic [7:0]  r_count, w_nxt_count;
  logic        r_sda_low, w_nxt_sda_low;
  logic        r_ack_drv, w_nxt_ack_drv;
  logic        r_rd_mode, w_nxt_rd_mode;
  logic        r_wr_strobe, w_nxt_wr_strobe;
  logic        w_mem_we;
  logic [7:0]  r_rd_data;
  logic [7:0]  r_mem [256];

  logic        w_scl, w_scl_rise, w_scl_fall;
  logic        w_sda, w_sda_rise, w_sda_fall;
  logic        w_start, w_stop;
  logic [7:0]  w_byte, w_tx;
  logic [2:0]  w_tx_idx;

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .xclk    (xclk),
    .reset_n (reset_n),
    .i_line  (scl_in),
    .o_level (w_scl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .xclk    (xclk),
    .reset_n (reset_n),
    .i_line  (sda_in),
    .o_level (w_sda),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  assign w_start  = w_sda_fall & w_scl;
  assign w_stop   = w_sda_rise & w_scl;
  assign w_byte   = {r_shift[6:0], w_sda};
  assign w_tx     = r_mem[r_ptr];
  assign w_tx_idx = 3'd7 - r_bit_cnt[2:0];

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_bit_cnt   = r_bit_cnt;
    w_nxt_shift     = r_shift;
    w_nxt_ptr       = r_ptr;
    w_nxt_wr_addr   = r_wr_addr;
    w_nxt_wr_data   = r_wr_data;
    w_nxt_count     = r_count;
    w_nxt_sda_low   = r_sda_low;
    w_nxt_ack_drv   = r_ack_drv;
    w_nxt_rd_mode   = r_rd_mode;
    w_nxt_wr_strobe = 1'b0;
    w_mem_we        = 1'b0;

    if (w_stop) begin
      w_nxt_state   = IDLE;
      w_nxt_bit_cnt = '0;
      w_nxt_sda_low = 1'b0;
      w_nxt_ack_drv = 1'b0;
    end else if (w_start) begin
      w_nxt_state   = DEV_ID;
      w_nxt_bit_cnt = '0;
      w_nxt_sda_low = 1'b0;
      w_nxt_ack_drv = 1'b0;
    end else begin
      case (r_state)
        DEV_ID, SUB_ADDR, WR_DATA: begin
          if (w_scl_rise) begin
            w_nxt_shift = w_byte;
            if (r_bit_cnt == 4'd7) begin
              w_nxt_bit_cnt = '0;
              w_nxt_ack_drv = 1'b0;
              if (r_state == DEV_ID) begin
                if (w_byte == DEV_ADDR) begin
                  w_nxt_state   = ACK_ID;
                  w_nxt_rd_mode = 1'b0;
                end else if (w_byte == (DEV_ADDR | 8'h01)) begin
                  w_nxt_state   = ACK_ID;
                  w_nxt_rd_mode = 1'b1;
                end else begin
                  w_nxt_state = IGNORE;
                end
              end else if (r_state == SUB_ADDR) begin
                w_nxt_ptr   = w_byte;
                w_nxt_state = ACK_SUB;
              end else begin
                w_mem_we        = 1'b1;
                w_nxt_wr_strobe = 1'b1;
                w_nxt_wr_addr   = r_ptr;
                w_nxt_wr_data   = w_byte;
                w_nxt_count     = r_count + 8'd1;
                w_nxt_ptr       = r_ptr + 8'd1;
                w_nxt_state     = ACK_DATA;
              end
            end else begin
              w_nxt_bit_cnt = r_bit_cnt + 4'd1;
            end
          end
        end

        // First falling edge asserts the ACK, the second one ends it.
        ACK_ID, ACK_SUB, ACK_DATA: begin
          if (w_scl_fall) begin
            if (!r_ack_drv) begin
              w_nxt_sda_low = 1'b1;
              w_nxt_ack_drv = 1'b1;
            end else begin
              w_nxt_ack_drv = 1'b0;
              w_nxt_sda_low = 1'b0;
              w_nxt_bit_cnt = '0;
              if (r_state == ACK_ID && r_rd_mode) begin
                w_nxt_state   = RD_DATA;
                w_nxt_sda_low = ~w_tx[7];
              end else if (r_state == ACK_ID) begin
                w_nxt_state = SUB_ADDR;
              end else begin
                w_nxt_state = WR_DATA;
              end
            end
          end
        end

        // r_bit_cnt counts bits already clocked out; the next bit goes out on the fall.
        RD_DATA: begin
          if (w_scl_rise && r_bit_cnt != 4'd8) begin
            w_nxt_bit_cnt = r_bit_cnt + 4'd1;
          end
          if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_nxt_sda_low = 1'b0;
              w_nxt_bit_cnt = '0;
              w_nxt_state   = RD_ACK;
            end else begin
              w_nxt_sda_low = ~w_tx[w_tx_idx];
            end
          end
        end

        RD_ACK: begin
          if (w_scl_rise) begin
            if (w_sda) begin
              w_nxt_state = IGNORE;
            end else begin
              w_nxt_ptr     = r_ptr + 8'd1;
              w_nxt_bit_cnt = '0;
              w_nxt_state   = RD_DATA;
            end
          end
        end

        IGNORE: begin
          w_nxt_sda_low = 1'b0;
        end

        default: begin
          w_nxt_sda_low = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge xclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_count     <= '0;
      r_sda_low   <= 1'b0;
      r_ack_drv   <= 1'b0;
      r_rd_mode   <= 1'b0;
      r_wr_strobe <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_bit_cnt   <= w_nxt_bit_cnt;
      r_shift     <= w_nxt_shift;
      r_ptr       <= w_nxt_ptr;
      r_wr_addr   <= w_nxt_wr_addr;
      r_wr_data   <= w_nxt_wr_data;
      r_count     <= w_nxt_count;
      r_sda_low   <= w_nxt_sda_low;
      r_ack_drv   <= w_nxt_ack_drv;
      r_rd_mode   <= w_nxt_rd_mode;
      r_wr_strobe <= w_nxt_wr_strobe;
    end
  end

  // Register file is deliberately not reset.
  always_ff @(posedge xclk) begin
    if (w_mem_we) begin
      r_mem[r_ptr] <= w_byte;
    end
    r_rd_data <= r_mem[rd_addr];
  end

  assign sda_drive_low = r_sda_low;
  assign wr_strobe     = r_wr_strobe;
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign write_count   = r_count;
  assign rd_data       = r_rd_data;
  assign busy          = (r_state != IDLE);

endmodule
